// File: rtl/alarm_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : alarm_keypad_scanner
// Purpose  : Scans a 4-row x 3-column alarm-clock keypad, debounces it over
//            whole scan frames and presents a held 4-bit key code plus a
//            one-cycle press strobe.
// Ports    : clock       - system clock
//            reset       - synchronous, active-high reset
//            row[3:0]    - keypad rows, active-low, asynchronous (row[0]=top)
//            col[2:0]    - column drives, active-low, one low at a time
//            key[3:0]    - debounced key code, 4'hF (NOKEY) when none held
//            key_pressed - one-cycle pulse when a new key is accepted
// Options  : `define MULTI_KEY_REJECT_EN -> a frame with more than one pressed
//            intersection reads as NOKEY. Otherwise the lowest column, then
//            the lowest row, wins.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key,
  output logic       key_pressed
);

  localparam int                SLOT_W      = $clog2(SCAN_DIV);
  localparam int                DB_W        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SLOT_W-1:0] C_SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   C_DB_LAST   = DB_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [3:0]        C_NOKEY     = 4'hF;

  typedef enum logic [1:0] {
    S_NO_KEY          = 2'd0,
    S_PRESS_PENDING   = 2'd1,
    S_KEY_HELD        = 2'd2,
    S_RELEASE_PENDING = 2'd3
  } state_t;

  // Key legend: rows 0..2 are the digits 1..9 laid out 3 per row, bottom row
  // is '*', '0', '#'.
  function automatic logic [3:0] key_code(input logic [1:0] c, input logic [1:0] r);
    logic [3:0] code;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = 4'hA;
        2'd1:    code = 4'h0;
        default: code = 4'hB;
      endcase
    end else begin
      code = 4'(r) * 4'd3 + 4'(c) + 4'd1;
    end
    return code;
  endfunction

  logic [3:0]        row_s1_q, row_s1_d, row_s2_q, row_s2_d;
  logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]        col_q, col_d;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [3:0]        code_q, code_d;       // first key seen in current frame
  state_t            state_q, state_d;
  logic [3:0]        cand_q, cand_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]        key_q, key_d;
  logic              key_pressed_q, key_pressed_d;
`ifdef MULTI_KEY_REJECT_EN
  logic              multi_q, multi_d;     // >1 intersection seen this frame
  logic              w_slot_multi;
  logic              w_frame_multi;
`endif

  logic       w_slot_end;
  logic       w_frame_done;
  logic       w_slot_hit;
  logic [3:0] w_slot_code;
  logic [3:0] w_first_code;
  logic [3:0] w_frame_code;

  assign w_slot_end   = (slot_cnt_q == C_SLOT_LAST);
  assign w_frame_done = w_slot_end && (col_idx_q == 2'd2);

  // Decode the synchronized rows for the active column. Walking from the
  // bottom row up leaves the lowest pressed row as the slot's code.
  always_comb begin
    w_slot_hit  = 1'b0;
    w_slot_code = C_NOKEY;
`ifdef MULTI_KEY_REJECT_EN
    w_slot_multi = 1'b0;
`endif
    for (int r = 3; r >= 0; r--) begin
      if (!row_s2_q[r]) begin
`ifdef MULTI_KEY_REJECT_EN
        if (w_slot_hit) w_slot_multi = 1'b1;
`endif
        w_slot_hit  = 1'b1;
        w_slot_code = key_code(col_idx_q, 2'(r));
      end
    end
  end

  // Columns are scanned in ascending order, so the first hit of the frame is
  // the lowest column.
  assign w_first_code = (code_q != C_NOKEY) ? code_q : w_slot_code;

`ifdef MULTI_KEY_REJECT_EN
  assign w_frame_multi = multi_q | w_slot_multi | ((code_q != C_NOKEY) & w_slot_hit);
  assign w_frame_code  = w_frame_multi ? C_NOKEY : w_first_code;
`else
  assign w_frame_code  = w_first_code;
`endif

  always_comb begin
    row_s1_d      = row;
    row_s2_d      = row_s1_q;
    slot_cnt_d    = slot_cnt_q + 1'b1;
    col_d         = col_q;
    col_idx_d     = col_idx_q;
    code_d        = code_q;
`ifdef MULTI_KEY_REJECT_EN
    multi_d       = multi_q;
`endif
    state_d       = state_q;
    cand_d        = cand_q;
    db_cnt_d      = db_cnt_q;
    key_d         = key_q;
    key_pressed_d = 1'b0;

    if (w_slot_end) begin
      slot_cnt_d = '0;
      col_d      = {col_q[1:0], col_q[2]};   // 110 -> 101 -> 011 -> 110
      col_idx_d  = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
      if (w_frame_done) begin
        code_d = C_NOKEY;
`ifdef MULTI_KEY_REJECT_EN
        multi_d = 1'b0;
`endif
      end else begin
        code_d = w_first_code;
`ifdef MULTI_KEY_REJECT_EN
        multi_d = w_frame_multi;
`endif
      end
    end

    if (w_frame_done) begin
      case (state_q)
        S_NO_KEY: begin
          if (w_frame_code != C_NOKEY) begin
            cand_d   = w_frame_code;
            db_cnt_d = DB_W'(1);
            if (DEBOUNCE_FRAMES == 1) begin
              key_d         = w_frame_code;
              key_pressed_d = 1'b1;
              state_d       = S_KEY_HELD;
            end else begin
              state_d = S_PRESS_PENDING;
            end
          end
        end
        S_PRESS_PENDING: begin
          if (w_frame_code == C_NOKEY) begin
            state_d = S_NO_KEY;
          end else if (w_frame_code == cand_q) begin
            if (db_cnt_q == C_DB_LAST) begin
              key_d         = cand_q;
              key_pressed_d = 1'b1;
              state_d       = S_KEY_HELD;
            end else begin
              db_cnt_d = db_cnt_q + 1'b1;
            end
          end else begin
            cand_d   = w_frame_code;
            db_cnt_d = DB_W'(1);
          end
        end
        S_KEY_HELD: begin
          if (w_frame_code != key_q) begin
            if (DEBOUNCE_FRAMES == 1) begin
              key_d   = C_NOKEY;
              state_d = S_NO_KEY;
            end else begin
              db_cnt_d = DB_W'(1);
              state_d  = S_RELEASE_PENDING;
            end
          end
        end
        S_RELEASE_PENDING: begin
          if (w_frame_code == key_q) begin
            state_d = S_KEY_HELD;          // short glitch, keep the key
          end else if (db_cnt_q == C_DB_LAST) begin
            key_d   = C_NOKEY;
            state_d = S_NO_KEY;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end
        default: state_d = S_NO_KEY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      row_s1_q      <= 4'hF;
      row_s2_q      <= 4'hF;
      slot_cnt_q    <= '0;
      col_q         <= 3'b110;
      col_idx_q     <= 2'd0;
      code_q        <= C_NOKEY;
`ifdef MULTI_KEY_REJECT_EN
      multi_q       <= 1'b0;
`endif
      state_q       <= S_NO_KEY;
      cand_q        <= C_NOKEY;
      db_cnt_q      <= '0;
      key_q         <= C_NOKEY;
      key_pressed_q <= 1'b0;
    end else begin
      row_s1_q      <= row_s1_d;
      row_s2_q      <= row_s2_d;
      slot_cnt_q    <= slot_cnt_d;
      col_q         <= col_d;
      col_idx_q     <= col_idx_d;
      code_q        <= code_d;
`ifdef MULTI_KEY_REJECT_EN
      multi_q       <= multi_d;
`endif
      state_q       <= state_d;
      cand_q        <= cand_d;
      db_cnt_q      <= db_cnt_d;
      key_q         <= key_d;
      key_pressed_q <= key_pressed_d;
    end
  end

  assign col         = col_q;
  assign key         = key_q;
  assign key_pressed = key_pressed_q;

endmodule
`default_nettype wire

// File: tb/tb_alarm_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_keypad_scanner
// Purpose  : Self-checking bench for alarm_keypad_scanner. A keypad model
//            drives the rows from the column drives and a frame-level
//            reference tracks the expected key, strobe and column pattern.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_keypad_scanner;

  localparam int          SCAN_DIV        = 4;
  localparam int          DEBOUNCE_FRAMES = 3;
  localparam int          FRAME           = 3 * SCAN_DIV;
  localparam logic [3:0]  C_NOKEY         = 4'hF;
  // Pressed-key masks, bit index = column*4 + row.
  localparam logic [11:0] P_1    = 12'h001;
  localparam logic [11:0] P_5    = 12'h020;
  localparam logic [11:0] P_0    = 12'h080;
  localparam logic [11:0] P_9    = 12'h400;
  localparam logic [11:0] P_HASH = 12'h800;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  key;
  logic        key_pressed;

  logic [11:0] pressed = '0;
  logic [3:0]  keymap [12];
  logic [2:0]  col_seq [3];
  logic [3:0]  hist [$];          // frame codes since the last key change
  logic [3:0]  exp_key;
  logic        exp_kp;
  int          n_edges;
  int          kp_count;
  int          kp0;
  int          errors = 0;
  int          checks = 0;

  alarm_keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key         (key),
    .key_pressed (key_pressed)
  );

  always #5 clock = ~clock;

  // Ideal keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 3; c++)
      if (col[c] == 1'b0)
        for (int r = 0; r < 4; r++)
          if (pressed[c*4 + r]) row[r] = 1'b0;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] frame_code(input logic [11:0] p);
    logic [3:0] f;
    f = C_NOKEY;
    for (int i = 11; i >= 0; i--)
      if (p[i]) f = keymap[i];
`ifdef MULTI_KEY_REJECT_EN
    if ($countones(p) > 1) f = C_NOKEY;
`endif
    return f;
  endfunction

  // Released: accept once the last DEBOUNCE_FRAMES frames agree on a real key.
  // Held: release once the last DEBOUNCE_FRAMES frames all differ from it.
  task automatic model_frame(input logic [3:0] f);
    int sz;
    bit tail_ok;
    hist.push_back(f);
    sz = hist.size();
    if (sz >= DEBOUNCE_FRAMES) begin
      tail_ok = 1'b1;
      for (int i = sz - DEBOUNCE_FRAMES; i < sz; i++) begin
        if (exp_key == C_NOKEY) begin
          if (hist[i] != f || f == C_NOKEY) tail_ok = 1'b0;
        end else if (hist[i] == exp_key) begin
          tail_ok = 1'b0;
        end
      end
      if (tail_ok) begin
        exp_kp  = (exp_key == C_NOKEY);
        exp_key = (exp_key == C_NOKEY) ? f : C_NOKEY;
        hist.delete();
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    exp_kp = 1'b0;
    if (reset) begin
      exp_key = C_NOKEY;
      n_edges = 0;
      hist.delete();
    end else begin
      n_edges++;
      if (n_edges % FRAME == 0) model_frame(frame_code(pressed));
    end
    if (key_pressed) kp_count++;
    check_val("col", {29'd0, col}, {29'd0, col_seq[(n_edges / SCAN_DIV) % 3]});
    check_val("key", {28'd0, key}, {28'd0, exp_key});
    check_val("key_pressed", {31'd0, key_pressed}, {31'd0, exp_kp});
  endtask

  task automatic run_frame(input logic [11:0] p);
    pressed = p;
    repeat (FRAME) step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [11:0] p;
    int          kind;
    int          hold;

    keymap   = '{4'h1, 4'h4, 4'h7, 4'hA, 4'h2, 4'h5, 4'h8, 4'h0, 4'h3, 4'h6, 4'h9, 4'hB};
    col_seq  = '{3'b110, 3'b101, 3'b011};
    exp_key  = C_NOKEY;
    exp_kp   = 1'b0;
    n_edges  = 0;
    kp_count = 0;

    do_reset();

    // Clean press of '5', then hold it.
    kp0 = kp_count;
    repeat (3) run_frame(P_5);
    check_val("press5_key", {28'd0, key}, 32'h5);
    check_val("press5_pulses", kp_count - kp0, 1);
    repeat (10) run_frame(P_5);
    check_val("hold5_pulses", kp_count - kp0, 1);

    // One-frame release glitch keeps the key; a full release clears it.
    run_frame('0);
    repeat (2) run_frame(P_5);
    check_val("glitch_key", {28'd0, key}, 32'h5);
    repeat (3) run_frame('0);
    check_val("release_key", {28'd0, key}, 32'hF);

    // Bounce: interrupted presses never reach the debounce count.
    kp0 = kp_count;
    repeat (2) run_frame(P_5);
    run_frame('0);
    repeat (2) run_frame(P_5);
    run_frame('0);
    check_val("bounce_key", {28'd0, key}, 32'hF);
    check_val("bounce_pulses", kp_count - kp0, 0);

    // '#' accepted exactly on its third frame.
    repeat (2) run_frame(P_HASH);
    check_val("hash_early", {28'd0, key}, 32'hF);
    run_frame(P_HASH);
    check_val("hash_key", {28'd0, key}, 32'hB);
    repeat (3) run_frame('0);

    // Chord '1' + '9'.
    repeat (3) run_frame(P_1 | P_9);
`ifdef MULTI_KEY_REJECT_EN
    check_val("chord_key", {28'd0, key}, 32'hF);
`else
    check_val("chord_key", {28'd0, key}, 32'h1);
`endif
    repeat (3) run_frame('0);

    // Reset in the middle of debouncing '0'.
    repeat (2) run_frame(P_0);
    do_reset();
    check_val("midreset_col", {29'd0, col}, 32'h6);
    repeat (2) run_frame(P_0);
    check_val("midreset_early", {28'd0, key}, 32'hF);
    run_frame(P_0);
    check_val("midreset_key", {28'd0, key}, 32'h0);
    repeat (3) run_frame('0);

    // Randomized segments of idle, single keys, chords and occasional resets.
    for (int s = 0; s < 200; s++) begin
      kind = int'($urandom_range(0, 39));
      hold = int'($urandom_range(1, 5));
      p    = '0;
      if (kind == 0) begin
        do_reset();
      end else begin
        if (kind < 14) begin
          p = '0;
        end else if (kind < 34) begin
          p[$urandom_range(0, 11)] = 1'b1;
        end else begin
          p[$urandom_range(0, 11)] = 1'b1;
          p[$urandom_range(0, 11)] = 1'b1;
        end
        repeat (hold) run_frame(p);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
